// File: rtl/enc_pkg.sv
// Shared types and helpers for the sequential priority encoder and related
// bitmap-to-index blocks.
package enc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NONE  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // A two-entry vector still needs one index bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_find_first.sv
// Combinational find-first-set over a bit vector, in either priority order.
// Also reports whether any bit, or exactly one bit, is set.
module prio_find_first
    import enc_pkg::*;
#(
    parameter int N         = 8,
    parameter bit LSB_FIRST = 1'b1,
    localparam int W        = idx_width(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         found,
    output logic         single
);

    localparam logic [N-1:0] LSB_ONE = {{(N-1){1'b0}}, 1'b1};

    // Scan away from the winning end so the winning bit is written last.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        if (LSB_FIRST) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (vec[i]) begin
                    idx   = W'(i);
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (vec[i]) begin
                    idx   = W'(i);
                    found = 1'b1;
                end
            end
        end
    end

    assign single = found && ((vec & (vec - LSB_ONE)) == '0);

endmodule

// File: rtl/seq_priority_encoder.sv
// Captures a request bitmap and streams out the index of each set bit, one
// per accepted beat, in priority order; an all-zero bitmap yields a single "none" beat.
module seq_priority_encoder
    import enc_pkg::*;
#(
    parameter int N         = 8,
    parameter bit LSB_FIRST = 1'b1,
    localparam int W        = idx_width(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic         out_none
);

    localparam logic [N-1:0] LSB_ONE = {{(N-1){1'b0}}, 1'b1};

    state_t         r_state;
    logic [N-1:0]   r_pending;

    logic [W-1:0]   w_idx;
    logic           w_found;
    logic           w_single;
    logic           w_in_fire;
    logic           w_out_fire;
    logic [N-1:0]   w_clear_mask;

    prio_find_first #(
        .N         (N),
        .LSB_FIRST (LSB_FIRST)
    ) u_find (
        .vec    (r_pending),
        .idx    (w_idx),
        .found  (w_found),
        .single (w_single)
    );

    // Outputs decode only r_state and r_pending, so they cannot glitch with out_ready.
    assign out_valid = (r_state != IDLE);
    assign out_none  = (r_state == NONE);
    assign out_last  = (r_state == NONE) | ((r_state == DRAIN) & w_found & w_single);
    assign out_idx   = (r_state == DRAIN) ? w_idx : '0;

    // Accepting on the final beat lets a new vector follow with no bubble.
    assign in_ready   = (r_state == IDLE) | (out_valid & out_ready & out_last);
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    assign w_clear_mask = LSB_ONE << w_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pending <= '0;
        end else if (w_in_fire) begin
            if (in_vec != '0) begin
                r_pending <= in_vec;
                r_state   <= DRAIN;
            end else begin
                r_pending <= '0;
                r_state   <= NONE;
            end
        end else if (w_out_fire) begin
            case (r_state)
                NONE: begin
                    r_state <= IDLE;
                end
                DRAIN: begin
                    r_pending <= r_pending & ~w_clear_mask;
                    if (out_last) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Scoreboard bench: two encoders (LSB-first and MSB-first) share one stimulus
// stream; each has its own queue of expected beats checked by a monitor.
module tb_seq_priority_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_vec;
    logic       out_ready;

    logic       a_in_ready, a_out_valid, a_out_last, a_out_none;
    logic [2:0] a_out_idx;
    logic       b_in_ready, b_out_valid, b_out_last, b_out_none;
    logic [2:0] b_out_idx;

    typedef struct packed {
        logic [2:0] idx;
        logic       last;
        logic       none;
    } beat_t;

    beat_t qa[$];
    beat_t qb[$];
    beat_t ea, eb;
    int    beat_cyc[$];
    int    cycle  = 0;
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    seq_priority_encoder #(.N(8), .LSB_FIRST(1'b1)) dut_lsb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (a_in_ready),
        .in_vec    (in_vec),
        .out_valid (a_out_valid),
        .out_ready (out_ready),
        .out_idx   (a_out_idx),
        .out_last  (a_out_last),
        .out_none  (a_out_none)
    );

    seq_priority_encoder #(.N(8), .LSB_FIRST(1'b0)) dut_msb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (b_in_ready),
        .in_vec    (in_vec),
        .out_valid (b_out_valid),
        .out_ready (out_ready),
        .out_idx   (b_out_idx),
        .out_last  (b_out_last),
        .out_none  (b_out_none)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_beat(input int ai, input bit al, input int bi, input bit bl, input bit none);
        qa.push_back('{idx: 3'(ai), last: al, none: none});
        qb.push_back('{idx: 3'(bi), last: bl, none: none});
    endtask

    // Monitor: every accepted output beat is matched against the queues.
    always @(negedge clk) begin
        if (rst_n && out_ready && a_out_valid) begin
            beat_cyc.push_back(cycle);
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL lsb_unexpected_beat: got idx %0d expected no beat", a_out_idx);
            end else begin
                ea = qa.pop_front();
                chk("lsb_idx",  32'(a_out_idx),  32'(ea.idx));
                chk("lsb_last", 32'(a_out_last), 32'(ea.last));
                chk("lsb_none", 32'(a_out_none), 32'(ea.none));
            end
        end
        if (rst_n && out_ready && b_out_valid) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL msb_unexpected_beat: got idx %0d expected no beat", b_out_idx);
            end else begin
                eb = qb.pop_front();
                chk("msb_idx",  32'(b_out_idx),  32'(eb.idx));
                chk("msb_last", 32'(b_out_last), 32'(eb.last));
                chk("msb_none", 32'(b_out_none), 32'(eb.none));
            end
        end
    end

    task automatic send(input logic [7:0] v);
        int n = 0;
        in_valid = 1'b1;
        in_vec   = v;
        @(negedge clk);
        while (!a_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!a_in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles");
        end
        chk("in_ready_match", 32'(b_in_ready), 32'(a_in_ready));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 50) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d/%0d beats outstanding expected 0", name, qa.size(), qb.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = 8'h00;
        out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_last",  32'(a_out_last),  32'd0);
        chk("rst_out_none",  32'(a_out_none),  32'd0);
        chk("rst_out_idx",   32'(a_out_idx),   32'd0);
        chk("rst_in_ready",  32'(a_in_ready),  32'd1);
        chk("rst_msb_valid", 32'(b_out_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 0000_0101: two beats, in_ready rises with the final beat
        expect_beat(0, 0, 2, 0, 0);
        expect_beat(2, 1, 0, 1, 0);
        send(8'h05);
        @(negedge clk);
        chk("t1_in_ready_beat1", 32'(a_in_ready), 32'd0);
        @(negedge clk);
        chk("t1_in_ready_beat2", 32'(a_in_ready), 32'd1);
        wait_drain("t1");

        // all ones: eight beats, last only at the far end
        for (int i = 0; i < 8; i++)
            expect_beat(i, i == 7, 7 - i, i == 7, 0);
        send(8'hFF);
        wait_drain("t2");

        // empty vector, then top bit only
        expect_beat(0, 1, 0, 1, 1);
        send(8'h00);
        wait_drain("t3a");
        expect_beat(7, 1, 7, 1, 0);
        send(8'h80);
        wait_drain("t3b");

        // backpressure on 1001_0000 with junk on in_vec during the stall
        out_ready = 1'b0;
        expect_beat(4, 0, 7, 0, 0);
        expect_beat(7, 1, 4, 1, 0);
        send(8'h90);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_vec   = (i == 0) ? 8'hFF : (i == 1) ? 8'h01 : 8'h00;
            @(negedge clk);
            chk("t4_hold_valid",    32'(a_out_valid), 32'd1);
            chk("t4_hold_lsb_idx",  32'(a_out_idx),   32'd4);
            chk("t4_hold_msb_idx",  32'(b_out_idx),   32'd7);
            chk("t4_hold_lsb_last", 32'(a_out_last),  32'd0);
            chk("t4_hold_in_ready", 32'(a_in_ready),  32'd0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain("t4");

        // back-to-back 0x03 then 0x40: three beats on consecutive cycles
        beat_cyc.delete();
        expect_beat(0, 0, 1, 0, 0);
        expect_beat(1, 1, 0, 1, 0);
        expect_beat(6, 1, 6, 1, 0);
        send(8'h03);
        send(8'h40);
        wait_drain("t5");
        chk("t5_beat_count", 32'(beat_cyc.size()), 32'd3);
        if (beat_cyc.size() == 3)
            chk("t5_no_bubble", 32'(beat_cyc[2] - beat_cyc[0]), 32'd2);

        // reset after the first beat of 0x0F
        expect_beat(0, 0, 3, 0, 0);
        send(8'h0F);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_lsb_valid", 32'(a_out_valid), 32'd0);
        chk("t6_rst_msb_valid", 32'(b_out_valid), 32'd0);
        chk("t6_rst_in_ready",  32'(a_in_ready),  32'd1);
        chk("t6_first_beat_seen", 32'(qa.size()), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t6_post_rst_valid", 32'(a_out_valid | b_out_valid), 32'd0);
            chk("t6_post_rst_ready", 32'(a_in_ready), 32'd1);
        end
        @(posedge clk); #1;
        expect_beat(5, 1, 5, 1, 0);
        send(8'h20);
        wait_drain("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
